// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the execute/memory stage and a
// word-addressed memory without byte enables. Sub-word stores run as
// read-modify-write; load results are lane-aligned and sign/zero-extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned/illegal
// requests with an err pulse instead of force-aligning them).
module lsu_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        mem_is_load,
  output logic        mem_is_store,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data,
  input  logic [31:0] mem_load_data
);

  localparam logic [2:0] F3_W = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        err_q;
  logic        mem_is_load_q;
  logic        mem_is_store_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_store_data_q;

  logic        req_illegal;
  logic        req_trap;
  logic [2:0]  req_f3;
  logic [1:0]  req_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic [31:0] st_merged;

  // Byte-address bits above the memory range are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Request decode: illegal codes run as W, sub-word lanes are force-aligned.
  always_comb begin
    req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_we && req_funct3[2]);
    req_f3      = req_illegal ? F3_W : req_funct3;
    case (req_f3[1:0])
      2'b00:   req_lane = req_addr[1:0];
      2'b01:   req_lane = {req_addr[1], 1'b0};
      default: req_lane = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned or illegal requests are trapped and never reach memory.
  assign req_trap = req_illegal ||
                    ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign req_trap = 1'b0;
`endif

  // Load-result formatting and sub-word store merge on the returned word.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_load_data[7:0];
      2'd1:    ld_byte = mem_load_data[15:8];
      2'd2:    ld_byte = mem_load_data[23:16];
      default: ld_byte = mem_load_data[31:24];
    endcase
    ld_half = lane_q[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    case (f3_q[1:0])
      2'b00:   ld_fmt = f3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = f3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_fmt = mem_load_data;
    endcase
    st_merged = mem_load_data;
    if (f3_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd0:    st_merged[7:0]   = wdata_q[7:0];
        2'd1:    st_merged[15:8]  = wdata_q[7:0];
        2'd2:    st_merged[23:16] = wdata_q[7:0];
        default: st_merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      st_merged[31:16] = wdata_q;
    end else begin
      st_merged[15:0] = wdata_q;
    end
  end

  // Access FSM with registered strobes, response and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      we_q             <= 1'b0;
      f3_q             <= 3'b000;
      lane_q           <= 2'b00;
      wdata_q          <= 16'h0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= 32'h0;
      err_q            <= 1'b0;
      mem_is_load_q    <= 1'b0;
      mem_is_store_q   <= 1'b0;
      mem_addr_q       <= 32'h0;
      mem_store_data_q <= 32'h0;
    end else begin
      rsp_valid_q    <= 1'b0;
      err_q          <= 1'b0;
      mem_is_load_q  <= 1'b0;
      mem_is_store_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (req_trap) begin
              err_q <= 1'b1;
            end else begin
              we_q       <= req_we;
              f3_q       <= req_f3;
              lane_q     <= req_lane;
              wdata_q    <= req_wdata[15:0];
              mem_addr_q <= 32'(req_addr[ADDR_WIDTH+1:2]);
              if (req_we && (req_f3[1:0] == 2'b10)) begin
                state_q          <= S_WR;
                mem_is_store_q   <= 1'b1;
                mem_store_data_q <= req_wdata;
              end else begin
                state_q       <= S_RD;
                mem_is_load_q <= 1'b1;
              end
            end
          end
        end
        S_RD: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (we_q) begin
            state_q          <= S_WR;
            mem_is_store_q   <= 1'b1;
            mem_store_data_q <= st_merged;
          end else begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ld_fmt;
          end
        end
        S_WR:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign err            = err_q;
  assign mem_is_load    = mem_is_load_q;
  assign mem_is_store   = mem_is_store_q;
  assign mem_addr       = mem_addr_q;
  assign mem_store_data = mem_store_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: vector table plus hand sequences, behavioural memory,
// queue scoreboard for load responses.
module tb_lsu_ctrl;

  localparam int unsigned AW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        mem_is_load;
  logic        mem_is_store;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] mem_load_data;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
    .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
    .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .mem_load_data(mem_load_data)
  );

  // Memory model: no reset, read data valid the cycle after the strobe.
  logic [31:0] mem [0:4095];
  logic        mem_init_done = 1'b0;
  int          n_loads = 0;
  int          n_stores = 0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[4]        <= 32'h8899AABB;
      mem[12]       <= 32'h11223344;
      mem[16]       <= 32'hCAFEF00D;
      mem_load_data <= 32'h0;
      mem_init_done <= 1'b1;
    end else begin
      if (mem_is_load) begin
        mem_load_data <= mem[mem_addr[11:0]];
        n_loads++;
      end
      if (mem_is_store) begin
        mem[mem_addr[11:0]] <= mem_store_data;
        n_stores++;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy_n;
    int          loads;
    int          stores;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One clock step, sampled at the falling edge, with the continuous monitors.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (mem_is_load && mem_is_store) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap: load and store strobes both high");
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %08h expected no response", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e);
      end
    end
`ifndef LSU_MISALIGN_TRAP_EN
    if (err !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL err_tied: got %b expected 0", err);
    end
`endif
  endtask

  // Present one request; optionally keep req_valid high while busy.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic hold, output int busy_n);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) busy_n++;
      else break;
    end
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int l0, s0, bn;
    l0 = n_loads;
    s0 = n_stores;
    if (!v.we) begin
      exp_q.push_back(v.rdata);
      last_rdata = v.rdata;
    end
    do_req(v.we, v.f3, v.addr, v.wdata, 1'b0, bn);
    check({name, "_busy"}, 32'(bn), 32'(v.busy_n));
    check({name, "_loads"}, 32'(n_loads - l0), 32'(v.loads));
    check({name, "_stores"}, 32'(n_stores - s0), 32'(v.stores));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({name, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({name, "_err"}, 32'(err), 32'h0);
    check({name, "_mem_is_load"}, 32'(mem_is_load), 32'h0);
    check({name, "_mem_is_store"}, 32'(mem_is_store), 32'h0);
    check({name, "_mem_addr"}, mem_addr, 32'h0);
    check({name, "_mem_store_data"}, mem_store_data, 32'h0);
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic trap_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input string name);
    int l0, s0;
    l0 = n_loads;
    s0 = n_stores;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = 32'hFFFFFFFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    tick();
    check({name, "_err"}, 32'(err), 32'h1);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_strobes"}, 32'({mem_is_load, mem_is_store}), 32'h0);
    tick();
    check({name, "_err_pulse"}, 32'(err), 32'h0);
    check({name, "_rdata_held"}, rsp_rdata, last_rdata);
    check({name, "_no_access"}, 32'((n_loads - l0) + (n_stores - s0)), 32'h0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, l0, s0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    last_rdata = 32'h0;

    // {we, f3, addr, wdata, expected rdata, busy cycles, loads, stores}
    vecs.push_back(vec_t'{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFF99, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 2, 1, 0});
    vecs.push_back(vec_t'{1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1, 0, 1});
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 2, 1, 0});
    vecs.push_back(vec_t'{1'b1, 3'b000, 32'h31, 32'hFFFFFFAA, 32'h0, 3, 1, 1});
    vecs.push_back(vec_t'{1'b1, 3'b001, 32'h32, 32'hFFFF5566, 32'h0, 3, 1, 1});
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'h30, 32'h0, 32'h5566AA44, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b101, 32'h30, 32'h0, 32'h0000AA44, 2, 1, 0});
`ifndef LSU_MISALIGN_TRAP_EN
    // Force-aligned misaligned accesses; illegal codes execute as W.
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'h41, 32'h0, 32'hCAFEF00D, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFF8899, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b011, 32'h22, 32'h0, 32'hDEADBEEF, 2, 1, 0});
    vecs.push_back(vec_t'{1'b1, 3'b101, 32'h4B, 32'h12345678, 32'h0, 1, 0, 1});
    vecs.push_back(vec_t'{1'b1, 3'b001, 32'h4B, 32'hFFFFABCD, 32'h0, 3, 1, 1});
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'h48, 32'h0, 32'hABCD5678, 2, 1, 0});
    vecs.push_back(vec_t'{1'b0, 3'b111, 32'h4B, 32'h0, 32'hABCD5678, 2, 1, 0});
`endif

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("reset");

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));
    check("sb_sh_word", mem[12], 32'h5566AA44);

`ifdef LSU_MISALIGN_TRAP_EN
    trap_req(1'b0, 3'b010, 32'h41, "trap_lw41");
    trap_req(1'b0, 3'b101, 32'h13, "trap_lhu13");
    trap_req(1'b1, 3'b001, 32'h33, "trap_sh33");
    trap_req(1'b1, 3'b100, 32'h30, "trap_st100");
    trap_req(1'b0, 3'b110, 32'h30, "trap_ld110");
    check("trap_mem_unchanged", mem[12], 32'h5566AA44);
`endif

    // req_valid held high through busy: exactly one access per request.
    l0 = n_loads;
    s0 = n_stores;
    exp_q.push_back(32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, bn);
    check("hold_lw_busy", 32'(bn), 32'd2);
    check("hold_lw_loads", 32'(n_loads - l0), 32'd1);
    s0 = n_stores;
    do_req(1'b1, 3'b010, 32'h28, 32'h0BADCAFE, 1'b1, bn);
    check("hold_sw_busy", 32'(bn), 32'd1);
    check("hold_sw_stores", 32'(n_stores - s0), 32'd1);
    run_vec(vec_t'{1'b0, 3'b010, 32'h28, 32'h0, 32'h0BADCAFE, 2, 1, 0}, "hold_rb");

    // Reset while an SB sits in RD_WAIT: no write follows.
    s0 = n_stores;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h30;
    req_wdata  = 32'h00000077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    tick();
    tick();
    check("rst_mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    repeat (3) tick();
    check("rst_mid_no_store", 32'(n_stores - s0), 32'h0);
    check("rst_mid_word", mem[12], 32'h5566AA44);
    run_vec(vec_t'{1'b0, 3'b010, 32'h30, 32'h0, 32'h5566AA44, 2, 1, 0}, "rst_rb");

    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
